// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the stream demultiplexer.
// DEMUX_STATS_EN enables the per-channel pop counters.
package stream_demux_pkg;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  typedef logic [1:0] occ_t;

  localparam logic SEL_OUT1 = 1'b1;
  localparam logic SEL_OUT2 = 1'b0;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// Two-entry channel FIFO with registered head, valid and ready.
// Reset clears occupancy only; data registers are don't-care.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [width-1:0] data_i,
  output logic             valid_o,
  output logic             ready_o,
  output logic [width-1:0] head_o
);

  occ_t             occ_q, occ_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;
  logic             do_push, do_pop;

  assign do_push = push_i && (occ_q < occ_t'(DEPTH));
  assign do_pop  = pop_i && (occ_q != '0);

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        occ_d = occ_q + 1'b1;
        if (occ_q == '0) head_d = data_i;
        else             tail_d = data_i;
      end
      2'b01: begin
        occ_d  = occ_q - 1'b1;
        head_d = tail_q;
      end
      2'b11: begin
        // push only reaches here below full, so occupancy is 1
        head_d = data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign valid_o = (occ_q != '0);
  assign ready_o = (occ_q < occ_t'(DEPTH));
  assign head_o  = head_q;

endmodule

// File: rtl/stream_demux.sv
// One-in, two-out stream demultiplexer with a 2-deep FIFO per channel.
// Define DEMUX_STATS_EN to count pops per channel (saturating).
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [width-1:0] in_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [width-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [width-1:0] out2_data,
  output logic [15:0]      count1,
  output logic [15:0]      count2
);

  logic rdy1, rdy2;
  logic push1, push2;
  logic pop1, pop2;

  assign in_ready = (in_sel == SEL_OUT1) ? rdy1 : rdy2;
  assign push1 = in_valid && (in_sel == SEL_OUT1) && rdy1;
  assign push2 = in_valid && (in_sel == SEL_OUT2) && rdy2;
  assign pop1  = out1_valid && out1_ready;
  assign pop2  = out2_valid && out2_ready;

  demux_slot #(.width(width)) u_slot1 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push1),
    .pop_i  (pop1),
    .data_i (in_data),
    .valid_o(out1_valid),
    .ready_o(rdy1),
    .head_o (out1_data)
  );

  demux_slot #(.width(width)) u_slot2 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push2),
    .pop_i  (pop2),
    .data_i (in_data),
    .valid_o(out2_valid),
    .ready_o(rdy2),
    .head_o (out2_data)
  );

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (pop1) cnt1_d = sat_inc(cnt1_q);
    if (pop2) cnt2_d = sat_inc(cnt2_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign count1 = cnt1_q;
  assign count2 = cnt2_q;
`else
  assign count1 = '0;
  assign count2 = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: expected words queued on
// acceptance, popped and compared when a channel hands one out.
module tb_stream_demux;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_sel;
  logic [W-1:0] in_data;
  logic         out1_valid, out1_ready;
  logic [W-1:0] out1_data;
  logic         out2_valid, out2_ready;
  logic [W-1:0] out2_data;
  logic [15:0]  count1, count2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

`ifdef DEMUX_STATS_EN
  localparam logic [15:0] EXP_CNT100 = 16'd100;
`else
  localparam logic [15:0] EXP_CNT100 = 16'd0;
`endif

  always #5 clk = ~clk;

  stream_demux #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .out2_valid(out2_valid),
    .out2_ready(out2_ready),
    .out2_data (out2_data),
    .count1    (count1),
    .count2    (count2)
  );

  // Inputs change at posedge+1, so negedge sees what the next edge uses.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (out1_valid && out1_ready) begin
        n_checks++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL out1_unexpected got=%h want=none", out1_data);
        end else begin
          e = q1.pop_front();
          if (out1_data !== e) begin
            n_fail++;
            $display("FAIL out1_data got=%h want=%h", out1_data, e);
          end
        end
      end
      if (out2_valid && out2_ready) begin
        n_checks++;
        if (q2.size() == 0) begin
          n_fail++;
          $display("FAIL out2_unexpected got=%h want=none", out2_data);
        end else begin
          e = q2.pop_front();
          if (out2_data !== e) begin
            n_fail++;
            $display("FAIL out2_data got=%h want=%h", out2_data, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel) q1.push_back(in_data);
        else        q2.push_back(in_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 1'b1;
    in_data = '0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out1_valid, out2_valid, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=001",
               {out1_valid, out2_valid, in_ready});
    end
    n_checks++;
    if ({count1, count2} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_counts got=%h want=0", {count1, count2});
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_data = 32'hA5A5_0001;
    out1_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_out1 got=%b/%h want=1/a5a50001",
               out1_valid, out1_data);
    end
    n_checks++;
    if (out2_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_out2 got=%b want=0", out2_valid);
    end
    cyc();
    n_checks++;
    if (out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain got=%b want=0", out1_valid);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h10 + W'(i);
      #1;
      n_checks++;
      if (in_ready !== (i < 2)) begin
        n_fail++;
        $display("FAIL bp_ready%0d got=%b want=%b", i, in_ready, i < 2);
      end
      cyc();
    end
    n_checks++;
    if (in_ready !== 1'b0 || out2_valid !== 1'b1 || out2_data !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_hold got=%b/%b/%h want=0/1/10",
               in_ready, out2_valid, out2_data);
    end
    // channel 2 full must not block channel 1
    in_sel = 1'b1;
    in_data = 32'h20;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cross_ready got=%b want=1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out1_valid !== 1'b1 || out1_data !== 32'h20) begin
      n_fail++;
      $display("FAIL cross_out1 got=%b/%h want=1/20", out1_valid, out1_data);
    end
    in_valid = 1'b1;
    in_sel = 1'b0;
    in_data = 32'h12;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      ok = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_accept got=0 want=1");
    end
    for (int i = 0; i < 20 && (q1.size() + q2.size()) != 0; i++) cyc();
    cyc();
    n_checks++;
    if (q1.size() + q2.size() != 0 || out2_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain got=%0d want=0", q1.size() + q2.size());
    end
  endtask

  task automatic test_back_to_back();
    int lows;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    lows = 0;
    in_valid = 1'b1;
    in_sel = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 32'h1000 + W'(i);
      #1;
      if (in_ready !== 1'b1) lows++;
      cyc();
    end
    in_valid = 1'b0;
    n_checks++;
    if (lows != 0) begin
      n_fail++;
      $display("FAIL b2b_ready_low got=%0d want=0", lows);
    end
    cyc();
    cyc();
    n_checks++;
    if (q1.size() != 0 || out1_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain got=%0d want=0", q1.size());
    end
    n_checks++;
    if (count1 !== EXP_CNT100 || count2 !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d/%0d want=%0d/0",
               count1, count2, EXP_CNT100);
    end
  endtask

  task automatic test_reset_full();
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = (i < 2);
      in_data = 32'h300 + W'(i);
      cyc();
    end
    in_valid = 1'b0;
    in_sel = 1'b1;
    #1;
    n_checks++;
    if ({out1_valid, out2_valid, in_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL full_flags got=%b want=110",
               {out1_valid, out2_valid, in_ready});
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({out1_valid, out2_valid, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rstfull_flags got=%b want=001",
               {out1_valid, out2_valid, in_ready});
    end
    in_sel = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || {count1, count2} !== 32'h0) begin
      n_fail++;
      $display("FAIL rstfull_ch2 got=%b/%h want=1/0",
               in_ready, {count1, count2});
    end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_saturate();
    out1_ready = 1'b0;
    force dut.cnt1_q = 16'hFFFD;
    cyc();
    release dut.cnt1_q;
    in_valid = 1'b1;
    in_sel = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h400 + W'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (count1 !== 16'hFFFF || count2 !== 16'h0) begin
      n_fail++;
      $display("FAIL sat_count got=%h/%h want=ffff/0", count1, count2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
`ifdef DEMUX_STATS_EN
    test_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
